// File: rtl/button_pkg.sv
// Shared definitions for the colour-button input port and the LED flash port:
// colour codes, memory-mapped addresses and the field layout of the read word.
package button_pkg;

  typedef enum logic [1:0] {
    COLOUR_RED    = 2'b00,
    COLOUR_BLUE   = 2'b01,
    COLOUR_GREEN  = 2'b10,
    COLOUR_YELLOW = 2'b11
  } colour_e;

  localparam logic [11:0] LED_ADDR    = 12'd6;
  localparam logic [11:0] BUTTON_ADDR = 12'd7;

  localparam int VALID_BIT    = 0;
  localparam int COLOUR_LSB   = 1;
  localparam int COLOUR_MSB   = 2;
  localparam int OVERFLOW_BIT = 3;

endpackage

// File: rtl/debouncer.sv
// One button: two-flop synchroniser, debounce counter and stable level register,
// with a one-cycle pulse on every accepted 0->1 transition of the stable level.
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;

  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    cnt_d    = '0;
    stable_d = stable_q;
    rise_d   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
        rise_d   = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;

endmodule

// File: rtl/button_input.sv
// Memory-mapped colour-button reader: debounced presses become colour codes queued
// in a small FIFO; each processor load from the button address pops one entry.
module button_input
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        red_button,
  input  logic        blue_button,
  input  logic        green_button,
  input  logic        yellow_button,
  input  logic        pop,
  output logic [31:0] data_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [3:0] raw_lvl, stable_lvl, rise_lvl, press;

  assign raw_lvl = {yellow_button, green_button, blue_button, red_button};

  for (genvar g = 0; g < 4; g++) begin : g_btn
    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
      .clock  (clock),
      .reset  (reset),
      .raw    (raw_lvl[g]),
      .stable (stable_lvl[g]),
      .rise   (rise_lvl[g])
    );
  end

  assign press = rise_lvl & stable_lvl;

  logic [3:0]       pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  colour_e          mem_q [FIFO_DEPTH];
  colour_e          mem_d [FIFO_DEPTH];

  logic    empty, full, pop_eff, enq;
  colour_e enq_sel;

  always_comb begin
    enq_sel = COLOUR_RED;
    for (int i = 3; i >= 0; i--) begin
      if (pending_q[i]) enq_sel = colour_e'(2'(i));
    end
  end

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CNT_W'(FIFO_DEPTH));
    pop_eff = pop && !empty;
    // A pop on the same edge frees the slot the enqueue needs.
    enq     = (|pending_q) && (!full || pop_eff);

    pending_d = pending_q;
    if (enq) pending_d[enq_sel] = 1'b0;
    pending_d = pending_d | (press & ~pending_q);

    overflow_d = pop ? 1'b0 : overflow_q;
    if (|(press & pending_q)) overflow_d = 1'b1;

    mem_d = mem_q;
    if (enq) mem_d[wr_ptr_q] = enq_sel;

    wr_ptr_d = wr_ptr_q + PTR_W'(enq);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_eff);
    count_d  = count_q + CNT_W'(enq) - CNT_W'(pop_eff);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= COLOUR_RED;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

  always_comb begin
    data_out               = '0;
    data_out[VALID_BIT]    = !empty;
    data_out[OVERFLOW_BIT] = overflow_q;
    if (!empty) data_out[COLOUR_MSB:COLOUR_LSB] = mem_q[rd_ptr_q];
  end

endmodule

// File: doc/button_input.md
# button_input

Memory-mapped input peripheral returning debounced colour-button presses to the processor. It is the read-side counterpart of the LED flash port: the processor stores a colour code to address 6 to light an LED, and loads from address 7 to collect which button the player pressed. The block synchronises and debounces the four raw buttons, converts each press into a colour-coded event, and queues events in a small FIFO. Each load pops one event.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz).
- FIFO_DEPTH, 4: event queue entries; power of two, ≥2.
- clock  in  1  system clock (50 MHz PLL output).
- reset  in  1  asynchronous, active-high; clears all state.
- red_button, blue_button, green_button, yellow_button  in  1 each  raw asynchronous button levels, active-high.
- pop  in  1  single-cycle pulse; the wrapper asserts it once per processor load from address 7.
- data_out  out  32  head-of-queue word; the wrapper muxes it onto memDataOut when the address is 7.

## Operation
- Colour codes match the LED port: red=00, blue=01, green=10, yellow=11.
- data_out fields:
  - [0] valid: FIFO not empty.
  - [2:1] colour of the head entry; 00 when empty.
  - [3] overflow flag.
  - [31:4] zero.
- Empty with no overflow reads 32'h0. Reset value is 32'h0.
- Per button: 2-flop synchroniser, then a debounce counter.
  - Counter clears whenever the synced level equals the stable level.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1 while the mismatch persists, the stable level flips and the counter clears.
- Press event = stable level 0→1. Releases generate nothing.
- Each event sets that button's pending bit.
- Each cycle, if the FIFO is not full (after accounting for a same-cycle pop), the lowest-coded pending button is enqueued and its pending bit cleared. At most one enqueue per cycle.
- Overflow is set when a press event arrives for a button whose pending bit is already set; that event is discarded.
- Overflow is cleared by any pop, including a pop on an empty FIFO.
- pop with the FIFO empty changes nothing except clearing overflow.
- pop and enqueue in the same cycle both take effect; when full this leaves the count unchanged.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. A count register, 0..FIFO_DEPTH, distinguishes full from empty.
- After reset, all stable levels are 0. A button held through reset therefore produces exactly one press event once debounced.

## Timing
- Press latency: raw rising edge sampled at clock edge N gives data_out valid after edge N+2+DEBOUNCE_CYCLES+1.
  - 2 synchroniser stages.
  - DEBOUNCE_CYCLES to accept the level.
  - 1 cycle for the pending bit to set.
  - Enqueue on the following edge.
- Any bounce shorter than DEBOUNCE_CYCLES restarts the count and produces no event.
- data_out is registered-state combinational: it reflects the head in the same cycle the entry is written. After a pop, the next entry appears the cycle after the pop edge.
- Throughput: one enqueue per cycle. Simultaneous presses drain in colour order on successive cycles.
- Reset asserted at any time clears synchronisers, counters, stable levels, pending bits, FIFO, pointers and overflow immediately. data_out reads 0 during reset.

## Structure
- Shared package button_pkg:
  - Colour code constants, shared with light_up.
  - BUTTON_ADDR = 12'd7 and LED_ADDR = 12'd6.
  - Field positions for valid, colour and overflow.
- Sub-module `debouncer`, instantiated four times, contains the synchroniser, counter and stable register. It outputs the stable level and a one-cycle rise pulse.
- The top level holds the pending bits, the priority select, the FIFO and the output word.

## Test plan
Directed tests use DEBOUNCE_CYCLES=4 and FIFO_DEPTH=4.
1. Reset, all buttons low, no pop for 20 cycles → data_out = 32'h0 throughout.
2. Red raised at edge 0 and held → data_out = 32'h1 from edge 7. pop → 32'h0 on the next cycle. Red released and held low 10 cycles → still 32'h0.
3. Blue toggles every 2 cycles for 12 cycles, then held high → exactly one event: data_out = 32'h3. After one pop → 32'h0.
4. Green and yellow raised on the same edge → data_out = 32'h5. After a pop → 32'h7. After a second pop → 32'h0.
5. Four presses fill the FIFO (red, blue, green, yellow; head 32'h1). A fifth red press stays pending. A sixth red press → data_out = 32'h9. pop → data_out = 32'h3, and the pending red enqueues at the tail.
6. Two events queued and yellow held high, then reset pulsed for 1 cycle → data_out = 32'h0 immediately. One yellow event (32'h7) appears 7 cycles after reset deasserts.
